// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: multi-cycle RV32M multiply/divide unit for the EX stage.
// Multiplies take two cycles. Divides use a 32-step restoring shift-subtract
// loop followed by a sign-fix cycle. Divide-by-zero and signed overflow
// complete in a single cycle.
// Optional build macro MULDIV_EARLY_OUT_EN: when defined, a divide with
// |B| > |A| also completes in one cycle (quotient 0, remainder = dividend).
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      FUNC3,
    input  logic [XLEN-1:0] OPERAND_A,
    input  logic [XLEN-1:0] OPERAND_B,
    input  logic            FLUSH,
    output logic [XLEN-1:0] RESULT,
    output logic            DONE,
    output logic            BUSY,
    output logic            STALL
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    // a_q: multiplicand, or dividend magnitude that shifts into the quotient
    // b_q: multiplier, or divisor magnitude
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] rem_q, rem_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;

    // Input-side decode used only at the sampling edge in IDLE
    logic        in_signed_s;
    logic        in_a_neg_s;
    logic        in_b_neg_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic        div_zero_s;
    logic        div_ovf_s;
    logic        early_out_s;

    // Datapath intermediates
    logic        sign_a_s;
    logic        sign_b_s;
    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;
    logic [63:0] product_s;
    logic [32:0] rem_shift_s;
    logic [32:0] rem_diff_s;
    logic [31:0] quo_fix_s;
    logic [31:0] rem_fix_s;

    // Operand magnitudes and divide special-case detection on the live inputs
    always_comb begin
        in_signed_s = ~FUNC3[0];
        in_a_neg_s  = in_signed_s & OPERAND_A[31];
        in_b_neg_s  = in_signed_s & OPERAND_B[31];
        if (in_a_neg_s) begin
            abs_a_s = 32'd0 - OPERAND_A;
        end else begin
            abs_a_s = OPERAND_A;
        end
        if (in_b_neg_s) begin
            abs_b_s = 32'd0 - OPERAND_B;
        end else begin
            abs_b_s = OPERAND_B;
        end
        div_zero_s = (OPERAND_B == 32'd0);
        div_ovf_s  = in_signed_s & (OPERAND_A == 32'h8000_0000) &
                     (OPERAND_B == 32'hFFFF_FFFF);
    end

`ifdef MULDIV_EARLY_OUT_EN
    assign early_out_s = (abs_b_s > abs_a_s);
`else
    assign early_out_s = 1'b0;
`endif

    // Product, one restoring-division step, and final sign correction
    always_comb begin
        // MULH and MUL sign-extend B; MULHSU/MULHU zero-extend it.
        // Only MULHU zero-extends A.
        sign_a_s  = (op_q[1:0] != 2'b11) & a_q[31];
        sign_b_s  = ~op_q[1] & b_q[31];
        mul_a_s   = {{32{sign_a_s}}, a_q};
        mul_b_s   = {{32{sign_b_s}}, b_q};
        product_s = mul_a_s * mul_b_s;

        rem_shift_s = {rem_q, a_q[31]};
        rem_diff_s  = rem_shift_s - {1'b0, b_q};

        if (neg_quo_q) begin
            quo_fix_s = 32'd0 - a_q;
        end else begin
            quo_fix_s = a_q;
        end
        if (neg_rem_q) begin
            rem_fix_s = 32'd0 - rem_q;
        end else begin
            rem_fix_s = rem_q;
        end
    end

    // Next-state and next-register computation; FLUSH overrides everything
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        if (FLUSH) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        op_d = FUNC3;
                        if (!FUNC3[2]) begin
                            a_d     = OPERAND_A;
                            b_d     = OPERAND_B;
                            state_d = S_MUL;
                        end else if (div_zero_s) begin
                            result_d = FUNC3[1] ? OPERAND_A : 32'hFFFF_FFFF;
                            done_d   = 1'b1;
                            state_d  = S_DONE;
                        end else if (div_ovf_s) begin
                            result_d = FUNC3[1] ? 32'd0 : 32'h8000_0000;
                            done_d   = 1'b1;
                            state_d  = S_DONE;
                        end else if (early_out_s) begin
                            result_d = FUNC3[1] ? OPERAND_A : 32'd0;
                            done_d   = 1'b1;
                            state_d  = S_DONE;
                        end else begin
                            a_d       = abs_a_s;
                            b_d       = abs_b_s;
                            rem_d     = 32'd0;
                            cnt_d     = 5'd0;
                            neg_quo_d = in_a_neg_s ^ in_b_neg_s;
                            neg_rem_d = in_a_neg_s;
                            state_d   = S_DIV;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_MUL: begin
                    if (op_q[1:0] == 2'b00) begin
                        result_d = product_s[31:0];
                    end else begin
                        result_d = product_s[63:32];
                    end
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
                S_DIV: begin
                    if (!rem_diff_s[32]) begin
                        rem_d = rem_diff_s[31:0];
                        a_d   = {a_q[30:0], 1'b1};
                    end else begin
                        rem_d = rem_shift_s[31:0];
                        a_d   = {a_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_DIV;
                    end
                end
                S_FIX: begin
                    result_d = op_q[1] ? rem_fix_s : quo_fix_s;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_FIX);
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            result_q  <= 32'd0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= 5'd0;
            op_q      <= 3'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            rem_q     <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign RESULT = result_q;
    assign DONE   = done_q;
    assign BUSY   = busy_q;
    assign STALL  = START & ~done_q & ~FLUSH;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed testbench for ex_muldiv_unit.
module tb_ex_muldiv_unit;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic [2:0]  FUNC3;
    logic [31:0] OPERAND_A;
    logic [31:0] OPERAND_B;
    logic        FLUSH;
    logic [31:0] RESULT;
    logic        DONE;
    logic        BUSY;
    logic        STALL;

    int pass_cnt;
    int chk_cnt;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EARLY_K = 1;
`else
    localparam int EARLY_K = 34;
`endif

    ex_muldiv_unit #(.XLEN(32)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .FUNC3     (FUNC3),
        .OPERAND_A (OPERAND_A),
        .OPERAND_B (OPERAND_B),
        .FLUSH     (FLUSH),
        .RESULT    (RESULT),
        .DONE      (DONE),
        .BUSY      (BUSY),
        .STALL     (STALL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Issue one op at a negedge in IDLE, hold START until DONE, return latency,
    // result and the number of cycles where STALL was wrong. Leaves unit in IDLE.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int k, output logic [31:0] res, output int stall_err);
        @(negedge CLK);
        START = 1'b1; FUNC3 = f; OPERAND_A = a; OPERAND_B = b;
        stall_err = 0; k = -1; res = 32'hDEAD_BEEF;
        #1;
        if (STALL !== 1'b1) stall_err++;
        for (int c = 1; c <= 100; c++) begin
            @(posedge CLK); #1;
            OPERAND_A = a ^ 32'h5A5A_0F0F;
            OPERAND_B = b ^ 32'h0F0F_A5A5;
            if (DONE === 1'b1) begin
                k = c;
                res = RESULT;
                if (STALL !== 1'b0) stall_err++;
                break;
            end
            if (STALL !== 1'b1) stall_err++;
        end
        START = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk_cnt++; if (RESULT !== 32'd0) $display("FAIL reset_result got=%h exp=%h", RESULT, 32'd0); else pass_cnt++;
        chk_cnt++; if (DONE !== 1'b0) $display("FAIL reset_done got=%b exp=0", DONE); else pass_cnt++;
        chk_cnt++; if (BUSY !== 1'b0) $display("FAIL reset_busy got=%b exp=0", BUSY); else pass_cnt++;
        chk_cnt++; if (STALL !== 1'b0) $display("FAIL reset_stall got=%b exp=0", STALL); else pass_cnt++;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_mul();
        logic [2:0]  f  [4] = '{3'b000, 3'b001, 3'b010, 3'b011};
        logic [31:0] av [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bv [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ev [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        int k; int se; logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            run_op(f[i], av[i], bv[i], k, r, se);
            chk_cnt++; if (k !== 2) $display("FAIL mul%0d_latency got=%0d exp=2", i, k); else pass_cnt++;
            chk_cnt++; if (r !== ev[i]) $display("FAIL mul%0d_result got=%h exp=%h", i, r, ev[i]); else pass_cnt++;
            chk_cnt++; if (se !== 0) $display("FAIL mul%0d_stall bad_cycles=%0d exp=0", i, se); else pass_cnt++;
        end
    endtask

    task automatic test_div();
        logic [2:0]  f  [5] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100};
        logic [31:0] av [5] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'h8000_0000};
        logic [31:0] bv [5] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd2};
        logic [31:0] ev [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hC000_0000};
        int k; int se; logic [31:0] r;
        for (int i = 0; i < 5; i++) begin
            run_op(f[i], av[i], bv[i], k, r, se);
            chk_cnt++; if (k !== 34) $display("FAIL div%0d_latency got=%0d exp=34", i, k); else pass_cnt++;
            chk_cnt++; if (r !== ev[i]) $display("FAIL div%0d_result got=%h exp=%h", i, r, ev[i]); else pass_cnt++;
            chk_cnt++; if (se !== 0) $display("FAIL div%0d_stall bad_cycles=%0d exp=0", i, se); else pass_cnt++;
        end
    endtask

    task automatic test_special();
        logic [2:0]  f  [6] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
        logic [31:0] av [6] = '{32'd100, 32'd100, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] bv [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] ev [6] = '{32'hFFFF_FFFF, 32'd100, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
        int k; int se; logic [31:0] r;
        for (int i = 0; i < 6; i++) begin
            run_op(f[i], av[i], bv[i], k, r, se);
            chk_cnt++; if (k !== 1) $display("FAIL spec%0d_latency got=%0d exp=1", i, k); else pass_cnt++;
            chk_cnt++; if (r !== ev[i]) $display("FAIL spec%0d_result got=%h exp=%h", i, r, ev[i]); else pass_cnt++;
        end
    endtask

    task automatic test_early_out();
        logic [2:0]  f  [4] = '{3'b101, 3'b111, 3'b100, 3'b110};
        logic [31:0] av [4] = '{32'd3, 32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
        logic [31:0] bv [4] = '{32'd10, 32'd10, 32'd10, 32'd10};
        logic [31:0] ev [4] = '{32'd0, 32'd3, 32'd0, 32'hFFFF_FFFD};
        int k; int se; logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            run_op(f[i], av[i], bv[i], k, r, se);
            chk_cnt++; if (k !== EARLY_K) $display("FAIL early%0d_latency got=%0d exp=%0d", i, k, EARLY_K); else pass_cnt++;
            chk_cnt++; if (r !== ev[i]) $display("FAIL early%0d_result got=%h exp=%h", i, r, ev[i]); else pass_cnt++;
        end
    endtask

    task automatic test_flush();
        int k; int se; int done_seen; logic [31:0] r;
        run_op(3'b101, 32'd100, 32'd7, k, r, se);
        chk_cnt++; if (r !== 32'd14) $display("FAIL flush_pre_result got=%h exp=%h", r, 32'd14); else pass_cnt++;
        @(negedge CLK);
        START = 1'b1; FUNC3 = 3'b100; OPERAND_A = 32'd1000; OPERAND_B = 32'd3;
        repeat (5) @(posedge CLK);
        #1;
        FLUSH = 1'b1;
        #1;
        chk_cnt++; if (STALL !== 1'b0) $display("FAIL flush_stall got=%b exp=0", STALL); else pass_cnt++;
        @(posedge CLK); #1;
        FLUSH = 1'b0; START = 1'b0;
        chk_cnt++; if (BUSY !== 1'b0) $display("FAIL flush_busy got=%b exp=0", BUSY); else pass_cnt++;
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (DONE !== 1'b0) done_seen++;
            @(posedge CLK); #1;
        end
        chk_cnt++; if (done_seen !== 0) $display("FAIL flush_no_done got=%0d exp=0", done_seen); else pass_cnt++;
        chk_cnt++; if (RESULT !== 32'd14) $display("FAIL flush_result_hold got=%h exp=%h", RESULT, 32'd14); else pass_cnt++;
        // FLUSH together with START in IDLE must not start anything
        @(negedge CLK);
        START = 1'b1; FLUSH = 1'b1; FUNC3 = 3'b000; OPERAND_A = 32'd9; OPERAND_B = 32'd9;
        @(posedge CLK); #1;
        START = 1'b0; FLUSH = 1'b0;
        chk_cnt++; if (BUSY !== 1'b0) $display("FAIL flush_idle_busy got=%b exp=0", BUSY); else pass_cnt++;
        @(posedge CLK); #1;
        chk_cnt++; if (DONE !== 1'b0) $display("FAIL flush_idle_done got=%b exp=0", DONE); else pass_cnt++;
        run_op(3'b000, 32'd3, 32'd4, k, r, se);
        chk_cnt++; if (k !== 2) $display("FAIL flush_mul_latency got=%0d exp=2", k); else pass_cnt++;
        chk_cnt++; if (r !== 32'd12) $display("FAIL flush_mul_result got=%h exp=%h", r, 32'd12); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int k; int se; logic [31:0] r;
        @(negedge CLK);
        START = 1'b1; FUNC3 = 3'b000; OPERAND_A = 32'd2; OPERAND_B = 32'd3;
        repeat (2) @(posedge CLK);
        #1;
        chk_cnt++; if (DONE !== 1'b1 || RESULT !== 32'd6) $display("FAIL b2b_first got=%b/%h exp=1/%h", DONE, RESULT, 32'd6); else pass_cnt++;
        OPERAND_A = 32'd6; OPERAND_B = 32'd7;
        @(posedge CLK); #1;
        chk_cnt++; if (DONE !== 1'b0 || BUSY !== 1'b0) $display("FAIL b2b_idle got=%b/%b exp=0/0", DONE, BUSY); else pass_cnt++;
        @(posedge CLK); #1;
        chk_cnt++; if (BUSY !== 1'b1) $display("FAIL b2b_busy got=%b exp=1", BUSY); else pass_cnt++;
        @(posedge CLK); #1;
        chk_cnt++; if (DONE !== 1'b1 || RESULT !== 32'd42) $display("FAIL b2b_second got=%b/%h exp=1/%h", DONE, RESULT, 32'd42); else pass_cnt++;
        START = 1'b0;
        @(posedge CLK); #1;
        k = 0; se = 0; r = 32'd0;
    endtask

    task automatic test_reset_mid_div();
        int k; int se; logic [31:0] r;
        @(negedge CLK);
        START = 1'b1; FUNC3 = 3'b101; OPERAND_A = 32'd100; OPERAND_B = 32'd7;
        repeat (10) @(posedge CLK);
        #2;
        chk_cnt++; if (BUSY !== 1'b1) $display("FAIL rst_mid_busy_before got=%b exp=1", BUSY); else pass_cnt++;
        RESET = 1'b1;
        #1;
        chk_cnt++; if (RESULT !== 32'd0) $display("FAIL rst_mid_result got=%h exp=%h", RESULT, 32'd0); else pass_cnt++;
        chk_cnt++; if (DONE !== 1'b0) $display("FAIL rst_mid_done got=%b exp=0", DONE); else pass_cnt++;
        chk_cnt++; if (BUSY !== 1'b0) $display("FAIL rst_mid_busy got=%b exp=0", BUSY); else pass_cnt++;
        START = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        run_op(3'b000, 32'd3, 32'd5, k, r, se);
        chk_cnt++; if (k !== 2) $display("FAIL rst_mid_mul_latency got=%0d exp=2", k); else pass_cnt++;
        chk_cnt++; if (r !== 32'd15) $display("FAIL rst_mid_mul_result got=%h exp=%h", r, 32'd15); else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        chk_cnt = 0;
        RESET = 1'b1;
        START = 1'b0;
        FLUSH = 1'b0;
        FUNC3 = 3'b000;
        OPERAND_A = 32'd0;
        OPERAND_B = 32'd0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_early_out();
        test_flush();
        test_back_to_back();
        test_reset_mid_div();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Multi-cycle RV32M multiply/divide unit in the EX stage. It is fed directly by the ID/EX pipeline register outputs: operands, FUNC3, and an M-extension select decoded from the ALU op. It holds the pipeline through STALL, which drives the ID/EX and upstream BUSYWAIT inputs. It returns a 32-bit result to the EX result mux, where it is selected in place of the ALU output.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.

Ports:
CLK  input  1  clock; all state updates on posedge.
RESET  input  1  asynchronous, active-high reset.
START  input  1  M-extension instruction present in EX. Held high by the stalled pipeline until the DONE cycle.
FUNC3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
OPERAND_A  input  XLEN  rs1 value (dividend / multiplicand).
OPERAND_B  input  XLEN  rs2 value (divisor / multiplier).
FLUSH  input  1  synchronous abort, e.g. a branch/jump resolved in EX.
RESULT  output  XLEN  registered result; holds its value until the next completion.
DONE  output  1  one-cycle pulse; RESULT is valid in this cycle.
BUSY  output  1  registered; high whenever state is not IDLE or DONE.
STALL  output  1  combinational: START & ~DONE & ~FLUSH.

Behaviour:
- States: IDLE, MUL, DIV, FIX, DONE. A 5-bit iteration counter is used in DIV.
- Reset (asynchronous, any state): state=IDLE, RESULT=0, DONE=0, BUSY=0, counter=0, all datapath registers=0.
- START is sampled only in IDLE. FUNC3 and the operands are latched at the sampling edge; later input changes are ignored.
- Latency k = the cycle in which DONE is high, with cycle 1 being the cycle right after the sampling edge.
- Multiply ops (FUNC3[2]=0), k=2:
  - IDLE->MUL, then MUL->DONE.
  - A 33x33 signed product is formed from sign- or zero-extended operands. MULH sign-extends both; MULHSU sign-extends A and zero-extends B; MULHU zero-extends both.
  - MUL returns product[31:0]. The other three return product[63:32].
- Divide special cases, checked at the sampling edge, k=1 (IDLE->DONE directly):
  - Divisor==0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
  - Signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Divide general case, k=34:
  - IDLE->DIV: latch |A|, |B| (raw values for unsigned ops) and the result signs. Counter=0.
  - DIV: 32 restoring shift-subtract iterations, one per cycle. The counter wraps 31->0 and the state moves to FIX on the 32nd iteration.
  - FIX: quotient is negated iff the signs of A and B differ (signed ops only). Remainder takes the sign of the dividend. Then move to DONE.
- DONE: DONE=1 and RESULT is valid. Unconditionally DONE->IDLE on the next edge, even if START is still high. A back-to-back M op is sampled in the following IDLE cycle.
- FLUSH: in any state, the next edge forces IDLE with no DONE pulse and RESULT unchanged. FLUSH together with START in IDLE does not start an operation. FLUSH has priority over every transition.
- START low in IDLE: no activity, outputs hold their values.
- All arithmetic is modulo 2^32. Negating 0x80000000 yields 0x80000000.

Optional Feature:
Macro MULDIV_EARLY_OUT_EN.
- Defined: a non-special divide with |B| > |A| (unsigned magnitude compare) completes with k=1. Quotient is 0; remainder is the original dividend.
- Undefined: such divides take the full k=34 path. Results are identical either way; only latency differs.

Test Plan:
- Reset asserted mid-DIV (cycle 10) -> RESULT=0, DONE=0, BUSY=0 immediately without a clock edge; state returns to IDLE.
- MUL A=7, B=0xFFFFFFFD -> DONE at k=2, RESULT=0xFFFFFFEB. MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (-7), B=2 -> k=34, RESULT=0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. STALL high in cycles 0..33 and low in the DONE cycle.
- DIVU 100/0 -> k=1, RESULT=0xFFFFFFFF. REMU 100/0 -> 100. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
- FLUSH at cycle 5 of a DIV -> no DONE pulse, RESULT keeps its prior value. A following MUL 3*4 issued in IDLE -> RESULT=12 at k=2.
- DIVU 3/10 -> RESULT=0, with k=1 if MULDIV_EARLY_OUT_EN is defined and k=34 otherwise.
